regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 85 ++++++++
 tb/tb_regfile_sb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// 32x32 register file with a pending-write scoreboard for decode stall detection.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regfile_sb (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic        re1,
   input  logic [4:0]  raddr1,
   output logic [31:0] rdata1,
   input  logic        re2,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata2,
   input  logic        mark_en,
   input  logic [4:0]  mark_addr,
   output logic        busy1,
   output logic        busy2,
   output logic [5:0]  pend_cnt
);

   logic [31:0] regs_q [32];
   logic [31:0] pending_q, pending_d;
   logic [5:0]  pend_cnt_q, pend_cnt_d;

   function automatic logic [5:0] popcount(input logic [31:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
      return c;
   endfunction

   // Mark is applied after clear so a new producer overrides a retiring one.
   always_comb begin
      pending_d = pending_q;
      if (we && waddr != 5'd0) pending_d[waddr] = 1'b0;
      if (mark_en && mark_addr != 5'd0) pending_d[mark_addr] = 1'b1;
      pend_cnt_d = popcount(pending_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
         pending_q  <= '0;
         pend_cnt_q <= '0;
      end else begin
         if (we && waddr != 5'd0) regs_q[waddr] <= wdata;
         pending_q  <= pending_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   always_comb begin
      rdata1 = '0;
      busy1  = 1'b0;
      if (!rst && re1 && raddr1 != 5'd0) begin
         rdata1 = regs_q[raddr1];
         busy1  = pending_q[raddr1];
`ifdef REGFILE_BYPASS_EN
         if (we && waddr == raddr1) begin
            rdata1 = wdata;
            busy1  = 1'b0;
         end
`endif
      end
   end

   always_comb begin
      rdata2 = '0;
      busy2  = 1'b0;
      if (!rst && re2 && raddr2 != 5'd0) begin
         rdata2 = regs_q[raddr2];
         busy2  = pending_q[raddr2];
`ifdef REGFILE_BYPASS_EN
         if (we && waddr == raddr2) begin
            rdata2 = wdata;
            busy2  = 1'b0;
         end
`endif
      end
   end

   assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reference model feeds an expected queue,
// plus directed scenarios with fixed expected values.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic        re1 = 1'b0;
   logic [4:0]  raddr1 = '0;
   logic [31:0] rdata1;
   logic        re2 = 1'b0;
   logic [4:0]  raddr2 = '0;
   logic [31:0] rdata2;
   logic        mark_en = 1'b0;
   logic [4:0]  mark_addr = '0;
   logic        busy1, busy2;
   logic [5:0]  pend_cnt;

   regfile_sb dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
      .mark_en(mark_en), .mark_addr(mark_addr),
      .busy1(busy1), .busy2(busy2), .pend_cnt(pend_cnt)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] m_regs [32];
   logic [31:0] m_pend;
   logic [5:0]  m_cnt;

   // Packed expectation: {rdata1, rdata2, busy1, busy2, pend_cnt}
   logic [71:0] exp_q[$];

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] obs_rdata1, obs_rdata2;
   logic        obs_busy1, obs_busy2;
   logic [5:0]  obs_cnt;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void exp_read(input logic re_v, input logic [4:0] a,
                                    output logic [31:0] d, output logic b);
      d = '0;
      b = 1'b0;
      if (!rst && re_v && a != 5'd0) begin
         d = m_regs[a];
         b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
         if (we && waddr == a) begin
            d = wdata;
            b = 1'b0;
         end
`endif
      end
   endfunction

   task automatic drive(input logic rst_v, input logic we_v, input logic [4:0] wa,
                        input logic [31:0] wd, input logic re1_v, input logic [4:0] ra1,
                        input logic re2_v, input logic [4:0] ra2,
                        input logic mk, input logic [4:0] ma);
      logic [31:0] e_d1, e_d2;
      logic        e_b1, e_b2;
      logic [71:0] e;
      @(negedge clk);
      rst = rst_v; we = we_v; waddr = wa; wdata = wd;
      re1 = re1_v; raddr1 = ra1; re2 = re2_v; raddr2 = ra2;
      mark_en = mk; mark_addr = ma;
      exp_read(re1_v, ra1, e_d1, e_b1);
      exp_read(re2_v, ra2, e_d2, e_b2);
      exp_q.push_back({e_d1, e_d2, e_b1, e_b2, m_cnt});
      #1;
      obs_rdata1 = rdata1; obs_rdata2 = rdata2;
      obs_busy1 = busy1; obs_busy2 = busy2; obs_cnt = pend_cnt;
      if (exp_q.size() == 0) begin
         check_val("queue_underflow", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check_val("rdata1", obs_rdata1, e[71:40]);
         check_val("rdata2", obs_rdata2, e[39:8]);
         check_val("busy1", {31'd0, obs_busy1}, {31'd0, e[7]});
         check_val("busy2", {31'd0, obs_busy2}, {31'd0, e[6]});
         check_val("pend_cnt", {26'd0, obs_cnt}, {26'd0, e[5:0]});
      end
      @(posedge clk);
      if (rst_v) begin
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_pend = '0;
         m_cnt  = '0;
      end else begin
         if (we_v && wa != 5'd0) begin
            m_regs[wa] = wd;
            m_pend[wa] = 1'b0;
         end
         if (mk && ma != 5'd0) m_pend[ma] = 1'b1;
         m_cnt = 6'($countones(m_pend));
      end
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pend = '0;
      m_cnt  = '0;

      // Reset state
      drive(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3);
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd0);
      check_val("reset_cnt", {26'd0, obs_cnt}, 32'd0);
      check_val("reset_rdata1", obs_rdata1, 32'd0);

      // Basic write then read
      drive(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
      check_val("w5_rdata1", obs_rdata1, 32'h1234_5678);
      check_val("w5_busy1", {31'd0, obs_busy1}, 32'd0);

      // Register zero is immutable and never pending
      drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      check_val("r0_rdata1", obs_rdata1, 32'd0);
      check_val("r0_busy1", {31'd0, obs_busy1}, 32'd0);
      check_val("r0_cnt", {26'd0, obs_cnt}, 32'd0);

      // Mark r3, retire it four cycles later
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd3);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0);
      check_val("m3_busy2", {31'd0, obs_busy2}, 32'd1);
      check_val("m3_cnt", {26'd0, obs_cnt}, 32'd1);
      idle();
      idle();
      drive(1'b0, 1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0);
      check_val("w3_busy2", {31'd0, obs_busy2}, 32'd0);
      check_val("w3_cnt", {26'd0, obs_cnt}, 32'd0);
      check_val("w3_rdata2", obs_rdata2, 32'h0000_0033);

      // Mark/write collision on r7
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
      drive(1'b0, 1'b1, 5'd7, 32'h0000_000A, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
      check_val("c7_rdata1", obs_rdata1, 32'h0000_000A);
      check_val("c7_busy1", {31'd0, obs_busy1}, 32'd1);
      check_val("c7_cnt", {26'd0, obs_cnt}, 32'd1);

      // r9 = 0x11 and pending, then same-cycle write-back of 0x22
      drive(1'b0, 1'b1, 5'd9, 32'h0000_0011, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
      drive(1'b0, 1'b1, 5'd9, 32'h0000_0022, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
`ifdef REGFILE_BYPASS_EN
      check_val("bp_rdata1", obs_rdata1, 32'h0000_0022);
      check_val("bp_busy1", {31'd0, obs_busy1}, 32'd0);
`else
      check_val("bp_rdata1", obs_rdata1, 32'h0000_0011);
      check_val("bp_busy1", {31'd0, obs_busy1}, 32'd1);
`endif

      // Reset mid-run discards regs and marks
      for (int r = 1; r <= 4; r++)
         drive(1'b0, 1'b1, 5'(r), 32'h100 + 32'(r), 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(r));
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b1, 5'd4, 1'b0, 5'd0);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b1, 5'd4, 1'b0, 5'd0);
      check_val("rst_rdata1", obs_rdata1, 32'd0);
      check_val("rst_rdata2", obs_rdata2, 32'd0);
      check_val("rst_busy", {30'd0, obs_busy1, obs_busy2}, 32'd0);
      check_val("rst_cnt", {26'd0, obs_cnt}, 32'd0);
      // Clearing an unmarked bit after reset is harmless
      drive(1'b0, 1'b1, 5'd2, 32'h0000_0BBB, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
      check_val("post_rst_rdata1", obs_rdata1, 32'h0000_0BBB);
      check_val("post_rst_cnt", {26'd0, obs_cnt}, 32'd0);

      // Random traffic against the model; small address range raises hazard density
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 59) == 0,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 11)), $urandom,
               1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 11)),
               1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 11)),
               1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)));
      end

      check_val("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
